// File: rtl/maxnet_feeder_if.sv
// Valid/ready streams around the maxnet feeder: activation words in, result word out.
interface maxnet_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;

  // Upstream/downstream side: drives words in and accepts the result.
  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_data
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/maxnet_feeder.sv
// Input stage for the maxnet engine: gathers a frame of N words, pulses start,
// waits (with watchdog) for done, and returns the result on a valid/ready stream.
module maxnet_feeder #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  maxnet_feeder_if.slave    bus,
  output logic [32*N-1:0]   vec_out,
  output logic              mx_start,
  input  logic              mx_done,
  input  logic [31:0]       mx_result,
  output logic              busy,
  output logic              err
);

  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [WDW-1:0] watchdog;

  // NOTE: all state, including the frame bank and handshake outputs, is updated
  // with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_COLLECT;
      count        <= '0;
      watchdog     <= '0;
      // NOTE: the bank is reset because the datapath sees it directly and a
      // cleared bank is the defined idle value downstream.
      vec_out      <= '0;
      mx_start     <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      bus.in_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
    end else begin
      mx_start <= 1'b0;
      unique case (state)
        S_COLLECT: begin
          if (bus.in_valid && bus.in_ready) begin
            vec_out[32*count +: 32] <= bus.in_data;
            if (bus.in_last || count == CW'(N - 1)) begin
              // Short frame: unused slots are zeroed, which maxnet treats as neutral.
              for (int k = 0; k < N; k++) begin
                if (k > int'(count)) vec_out[32*k +: 32] <= '0;
              end
              count        <= '0;
              state        <= S_START;
              mx_start     <= 1'b1;
              busy         <= 1'b1;
              bus.in_ready <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        S_START: begin
          // Any done seen here belongs to a previous run and is ignored.
          watchdog <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (mx_done) begin
            bus.res_data  <= mx_result;
            bus.res_valid <= 1'b1;
            state         <= S_OUT;
          end else if (watchdog == WDW'(TIMEOUT)) begin
            err          <= 1'b1;
            state        <= S_COLLECT;
            busy         <= 1'b0;
            bus.in_ready <= 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        S_OUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= S_COLLECT;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end

        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed self-checking bench for maxnet_feeder (N=4, TIMEOUT=8).
module tb_maxnet_feeder;
  localparam int N       = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [32*N-1:0]   vec_out;
  logic              mx_start;
  logic              mx_done;
  logic [31:0]       mx_result;
  logic              busy;
  logic              err;

  int n_cmp = 0;
  int n_err = 0;

  maxnet_feeder_if bus ();

  maxnet_feeder #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .vec_out   (vec_out),
    .mx_start  (mx_start),
    .mx_done   (mx_done),
    .mx_result (mx_result),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic done_pulse(input logic [31:0] r);
    mx_done   = 1'b1;
    mx_result = r;
    tick();
    mx_done   = 1'b0;
  endtask

  initial begin
    logic [127:0] bank;

    // T1: reset with input activity present
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; bus.in_last = 1'b0;
    bus.res_ready = 1'b0; mx_done = 1'b0; mx_result = 32'h0;
    tick(); tick();
    chk("rst_vec",       vec_out, '0);
    chk("rst_start",     mx_start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data",  bus.res_data, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_err",       err, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rel_in_ready",  bus.in_ready, 1);
    chk("rel_vec",       vec_out, '0);

    // T2: full frame, done 5 cycles after start
    send_word(32'h3F800000, 1'b0);
    send_word(32'h40000000, 1'b0);
    send_word(32'hC0000000, 1'b0);
    chk("t2_no_start_early", mx_start, 0);
    send_word(32'h3F000000, 1'b0);
    chk("t2_start",    mx_start, 1);
    chk("t2_busy",     busy, 1);
    chk("t2_in_ready", bus.in_ready, 0);
    chk("t2_vec", vec_out, {32'h3F000000, 32'hC0000000, 32'h40000000, 32'h3F800000});
    tick();
    chk("t2_start_one_cycle", mx_start, 0);
    tick(); tick(); tick(); tick();
    chk("t2_no_res_yet", bus.res_valid, 0);
    done_pulse(32'h40000000);
    chk("t2_res_valid", bus.res_valid, 1);
    chk("t2_res_data",  bus.res_data, 32'h40000000);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("t2_res_drop",  bus.res_valid, 0);
    chk("t2_in_ready",  bus.in_ready, 1);
    chk("t2_idle",      busy, 0);

    // in_last without in_valid is ignored
    bus.in_last = 1'b1;
    tick();
    bus.in_last = 1'b0;
    chk("last_no_valid_busy", busy, 0);
    chk("last_no_valid_start", mx_start, 0);

    // T3: short frame, slots 2,3 zero-filled
    send_word(32'h41200000, 1'b0);
    send_word(32'h41A00000, 1'b1);
    chk("t3_start", mx_start, 1);
    bank = {32'h0, 32'h0, 32'h41A00000, 32'h41200000};
    chk("t3_vec", vec_out, bank);
    tick();
    done_pulse(32'h3F800000);

    // T4: backpressure, input offered while busy
    bus.in_valid = 1'b1; bus.in_data = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_res_valid", bus.res_valid, 1);
      chk("t4_res_data",  bus.res_data, 32'h3F800000);
      chk("t4_in_ready",  bus.in_ready, 0);
    end
    chk("t4_vec_held", vec_out, bank);
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("t4_res_drop", bus.res_valid, 0);
    chk("t4_in_ready", bus.in_ready, 1);

    // T5: watchdog timeout, then a normal frame with err held
    send_word(32'h00000001, 1'b0);
    send_word(32'h00000002, 1'b0);
    send_word(32'h00000003, 1'b0);
    send_word(32'h00000004, 1'b0);
    tick();  // now in WAIT, watchdog = 0
    for (int i = 0; i < TIMEOUT; i++) tick();
    chk("t5_err_not_yet", err, 0);
    chk("t5_busy_wait",   busy, 1);
    tick();
    chk("t5_err",       err, 1);
    chk("t5_collect",   busy, 0);
    chk("t5_in_ready",  bus.in_ready, 1);
    chk("t5_no_res",    bus.res_valid, 0);
    chk("t5_res_data_kept", bus.res_data, 32'h3F800000);
    send_word(32'h40400000, 1'b0);
    send_word(32'h40800000, 1'b0);
    send_word(32'h40A00000, 1'b0);
    send_word(32'h40C00000, 1'b0);
    tick();
    tick();
    done_pulse(32'h40C00000);
    chk("t5_res_valid2", bus.res_valid, 1);
    chk("t5_res_data2",  bus.res_data, 32'h40C00000);
    chk("t5_err_sticky", err, 1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // T6: stale done in START, reset during WAIT
    send_word(32'h3F800000, 1'b0);
    send_word(32'h3F800000, 1'b0);
    send_word(32'h3F800000, 1'b0);
    send_word(32'h3F800000, 1'b0);
    chk("t6_start", mx_start, 1);
    done_pulse(32'h12345678);
    chk("t6_stale_ignored", bus.res_valid, 0);
    chk("t6_wait_busy",     busy, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_rst_busy",  busy, 0);
    chk("t6_rst_vec",   vec_out, '0);
    chk("t6_rst_err",   err, 0);
    chk("t6_rst_ready", bus.in_ready, 1);
    rst = 1'b1;
    tick();
    chk("t6_no_res",    bus.res_valid, 0);
    chk("t6_res_data",  bus.res_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
